// File: rtl/dm_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_resp_pkg;

  // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15).
  localparam int unsigned CNT_W = 4;
  // Byte-offset bits within a 32-bit word.
  localparam int unsigned OFS_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_t;

endpackage

// File: rtl/dm_storage.sv
// Byte-organised storage with big-endian 32-bit word access.
// Writes are synchronous on clk; the word read is combinational so the
// responder can register it on the same edge that commits a store. No reset:
// contents survive a responder reset.
module dm_storage
  import dm_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-OFS_W-1:0] widx,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [7:0] mem [Depth];

  // Word write: MSB lands on the lowest byte address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{widx, 2'b00}] <= wdata[31:24];
      mem[{widx, 2'b01}] <= wdata[23:16];
      mem[{widx, 2'b10}] <= wdata[15:8];
      mem[{widx, 2'b11}] <= wdata[7:0];
    end
  end

  assign rdata = {mem[{widx, 2'b00}], mem[{widx, 2'b01}],
                  mem[{widx, 2'b10}], mem[{widx, 2'b11}]};

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with a valid/ready request handshake,
// WAIT_CYCLES wait states and a one-cycle response strobe.
// Optional feature: define DM_RESP_MISALIGN_CHECK_EN to reject misaligned
// accesses with Resp_Err; otherwise accesses are forced word-aligned.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  output logic        Resp_Valid,
  output logic [31:0] MemReadData,
  output logic        Resp_Err
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              store_q;

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_store;
  logic              misalign;
  logic              st_we;
  logic [31:0]       st_rdata;

  assign accept = Req_Valid && Req_Ready && (MemRead || MemWrite);

  // With zero wait states the access happens on the accept edge itself, so
  // the live request is used while idle; otherwise the captured copy.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_store = store_q;
    if (state_q == StIdle) begin
      acc_addr  = MemAddr[ADDR_W-1:0];
      acc_wdata = MemWriteData;
      acc_store = MemWrite;
    end
  end

  assign enter_resp = !rst &&
                      (((state_q == StWait) && (cnt_q == '0)) ||
                       ((state_q == StIdle) && accept && (WAIT_CYCLES == 0)));

`ifdef DM_RESP_MISALIGN_CHECK_EN
  assign misalign = (acc_addr[OFS_W-1:0] != '0);
`else
  assign misalign = 1'b0;
  logic unused_ofs;
  assign unused_ofs = ^acc_addr[OFS_W-1:0];
`endif

  // Upper address bits are ignored, which makes high addresses wrap.
  logic unused_addr;
  assign unused_addr = ^MemAddr[31:ADDR_W];

  assign st_we = enter_resp && acc_store && !misalign;

  dm_storage #(
    .ADDR_W(ADDR_W)
  ) u_storage (
    .clk  (clk),
    .we   (st_we),
    .widx (acc_addr[ADDR_W-1:OFS_W]),
    .wdata(acc_wdata),
    .rdata(st_rdata)
  );

  // FSM, wait counter, request capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      store_q     <= 1'b0;
      Req_Ready   <= 1'b1;
      Resp_Valid  <= 1'b0;
      MemReadData <= '0;
      Resp_Err    <= 1'b0;
    end else begin
      Resp_Valid <= 1'b0;
      Resp_Err   <= 1'b0;
      if (enter_resp) begin
        Resp_Valid <= 1'b1;
        Resp_Err   <= misalign;
        if (misalign) begin
          MemReadData <= '0;
        end else if (!acc_store) begin
          MemReadData <= st_rdata;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q    <= MemAddr[ADDR_W-1:0];
            wdata_q   <= MemWriteData;
            store_q   <= MemWrite;  // read+write together counts as a store
            Req_Ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          state_q   <= StIdle;
          Req_Ready <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          Req_Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder (ADDR_W=10, WAIT_CYCLES=2).
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Resp_Valid;
  logic [31:0] MemReadData;
  logic        Resp_Err;

  dm_responder #(
    .ADDR_W     (10),
    .WAIT_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemAddr     (MemAddr),
    .MemWriteData(MemWriteData),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Req_Valid   (Req_Valid),
    .Req_Ready   (Req_Ready),
    .Resp_Valid  (Resp_Valid),
    .MemReadData (MemReadData),
    .Resp_Err    (Resp_Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && Resp_Valid) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got Resp_Valid=1 at cycle %0d want none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check32("resp_cycle", 32'(cyc), 32'(e.cyc));
        check32("rdata", MemReadData, e.rd);
        check32("err", {31'h0, Resp_Err}, {31'h0, e.err});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!Req_Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!Req_Ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got Req_Ready=0 want 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    wait_ready();
  endtask

  // Issue one request at a negedge; expectation is pushed for accept+3 edges.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    wait_ready();
    MemAddr      = a;
    MemWriteData = d;
    MemRead      = rd;
    MemWrite     = wr;
    Req_Valid    = 1'b1;
    e.cyc = cyc + 3;
    e.rd  = exp_rd;
    e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    Req_Valid    = 1'b0;
    MemAddr      = 32'hFFFF_FFFF;
    MemWriteData = 32'h0BAD_0BAD;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    do_req(a, d, 1'b0, 1'b1, last_rd, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err);
    do_req(a, 32'h0, 1'b1, 1'b0, exp_rd, exp_err);
    last_rd = exp_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cnt;
    rst          = 1'b1;
    Req_Valid    = 1'b0;
    MemAddr      = 32'h0;
    MemWriteData = 32'h0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    repeat (3) @(negedge clk);
    check32("rst_ready", {31'h0, Req_Ready}, 32'h1);
    check32("rst_valid", {31'h0, Resp_Valid}, 32'h0);
    check32("rst_rdata", MemReadData, 32'h0);
    check32("rst_err", {31'h0, Resp_Err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic store/load.
    store(32'h10, 32'hDEAD_BEEF);
    load(32'h10, 32'hDEAD_BEEF, 1'b0);

    // Big-endian byte layout.
    store(32'h20, 32'h1122_3344);
    load(32'h20, 32'h1122_3344, 1'b0);
    drain();
    check32("byte_20", {24'h0, dut.u_storage.mem[32'h20]}, 32'h11);
    check32("byte_23", {24'h0, dut.u_storage.mem[32'h23]}, 32'h44);

    // Back-to-back loads with Req_Valid held high.
    base_cnt     = resp_cnt;
    MemAddr      = 32'h10;
    MemRead      = 1'b1;
    MemWrite     = 1'b0;
    Req_Valid    = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check32("b2b_ready", {31'h0, Req_Ready}, (k % 4 == 0) ? 32'h1 : 32'h0);
      if (Req_Ready) begin
        exp_t e;
        e.cyc = cyc + 3;
        e.rd  = 32'hDEAD_BEEF;
        e.err = 1'b0;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    Req_Valid = 1'b0;
    MemRead   = 1'b0;
    last_rd   = 32'hDEAD_BEEF;
    drain();
    check32("b2b_resp_count", 32'(resp_cnt - base_cnt), 32'd3);

    // Address wrap at 2^ADDR_W.
    store(32'h404, 32'hCAFE_F00D);
    load(32'h004, 32'hCAFE_F00D, 1'b0);

    // Known contents at 0x30, then abort a store to it with reset.
    store(32'h30, 32'hA5A5_0030);
    drain();
    MemAddr      = 32'h30;
    MemWriteData = 32'h1234_5678;
    MemWrite     = 1'b1;
    Req_Valid    = 1'b1;
    @(negedge clk);
    Req_Valid = 1'b0;
    MemWrite  = 1'b0;
    rst       = 1'b1;
    #1;
    check32("abort_ready", {31'h0, Req_Ready}, 32'h1);
    check32("abort_valid", {31'h0, Resp_Valid}, 32'h0);
    check32("abort_rdata", MemReadData, 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    last_rd = 32'h0;
    repeat (3) @(negedge clk);
    load(32'h30, 32'hA5A5_0030, 1'b0);

    // Misaligned load, then combined read+write (treated as a store).
`ifdef DM_RESP_MISALIGN_CHECK_EN
    load(32'h31, 32'h0, 1'b1);
`else
    load(32'h31, 32'hA5A5_0030, 1'b0);
`endif
    do_req(32'h40, 32'h55AA_55AA, 1'b1, 1'b1, last_rd, 1'b0);
    load(32'h40, 32'h55AA_55AA, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
